wb_dram_narrow_bridge: RTL and testbench

- Width adapter between the CPU core's 32-bit Wishbone data port and the 128-bit DRAM user Wishbone port.
- Converts each 32-bit classic-cycle access into one 128-bit DRAM access: lane steering for writes, lane extraction for reads, error and timeout handling.
- Sits directly upstream of the DRAM controller's user port 0 and consumes the core's memory requests.

---
 rtl/wb_dram_narrow_bridge.sv | 253 +++++++++++++++++++++++++
 tb/tb_wb_dram_narrow_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dram_narrow_bridge.sv
// 32-bit Wishbone classic slave to 128-bit DRAM user-port master width adapter.
// Define WB_BRIDGE_LINEBUF_EN to add a single-line write-through read buffer.
module wb_dram_narrow_bridge #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  s_adr,
    input  logic [31:0]  s_dat_i,
    output logic [31:0]  s_dat_o,
    input  logic         s_we,
    input  logic [3:0]   s_sel,
    input  logic         s_stb,
    input  logic         s_cyc,
    output logic         s_ack,
    output logic         s_err,
    output logic [31:0]  m_adr,
    output logic [127:0] m_dat_o,
    input  logic [127:0] m_dat_i,
    output logic         m_we,
    output logic [15:0]  m_sel,
    output logic         m_stb,
    output logic         m_cyc,
    input  logic         m_ack,
    input  logic         m_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
`ifdef WB_BRIDGE_LINEBUF_EN
        , ST_HIT = 2'd3
`endif
    } state_t;

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    state_t          state_r;
    state_t          next_state_s;
    logic [1:0]      lane_r;
    logic            abort_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            req_s;
    logic            done_s;
    logic            timeout_s;
    logic            bus_err_s;
    logic            deliver_s;
    logic            unused_s;

    logic [31:0]     s_dat_o_r;
    logic            s_ack_r;
    logic            s_err_r;
    logic [31:0]     m_adr_r;
    logic [127:0]    m_dat_o_r;
    logic            m_we_r;
    logic [15:0]     m_sel_r;
    logic            m_cyc_r;

    function automatic logic [31:0] pick_word(input logic [127:0] line, input logic [1:0] lane);
        return line[{lane, 5'b00000} +: 32];
    endfunction

`ifdef WB_BRIDGE_LINEBUF_EN
    logic [127:0] lb_data_r;
    logic [27:0]  lb_tag_r;
    logic         lb_valid_r;
    logic         lb_hit_s;
    logic         line_hit_s;

    function automatic logic [127:0] merge_bytes(input logic [127:0] old_line,
                                                 input logic [127:0] new_line,
                                                 input logic [15:0]  sel);
        logic [127:0] res;
        res = old_line;
        for (int i = 0; i < 16; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_line[8*i +: 8];
            end
        end
        return res;
    endfunction
`endif

    assign unused_s = ^s_adr[1:0];

    // Handshake decode; a simultaneous ack and err counts as an error.
    always_comb begin
        req_s     = s_cyc & s_stb;
        done_s    = m_ack | m_err;
        if (TO_EN && (state_r == ST_REQ) && !done_s && (to_cnt_r == TO_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        bus_err_s = m_err | timeout_s;
        deliver_s = s_cyc & ~abort_r;
`ifdef WB_BRIDGE_LINEBUF_EN
        lb_hit_s   = ~s_we & lb_valid_r & (lb_tag_r == s_adr[31:4]);
        line_hit_s = lb_valid_r & (lb_tag_r == m_adr_r[31:4]);
`endif
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
`ifdef WB_BRIDGE_LINEBUF_EN
                    if (lb_hit_s) begin
                        next_state_s = ST_HIT;
                    end else begin
                        next_state_s = ST_REQ;
                    end
`else
                    next_state_s = ST_REQ;
`endif
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (done_s || timeout_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
`ifdef WB_BRIDGE_LINEBUF_EN
            ST_HIT:  next_state_s = ST_IDLE;
`endif
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture, DRAM handshake, timeout count and core-side response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_r    <= 2'b00;
            abort_r   <= 1'b0;
            to_cnt_r  <= '0;
            s_dat_o_r <= 32'h0000_0000;
            s_ack_r   <= 1'b0;
            s_err_r   <= 1'b0;
            m_adr_r   <= 32'h0000_0000;
            m_dat_o_r <= 128'h0;
            m_we_r    <= 1'b0;
            m_sel_r   <= 16'h0000;
            m_cyc_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        lane_r    <= s_adr[3:2];
                        abort_r   <= 1'b0;
                        m_adr_r   <= {s_adr[31:4], 4'b0000};
                        m_we_r    <= s_we;
                        m_sel_r   <= {12'h000, s_sel} << {s_adr[3:2], 2'b00};
                        m_dat_o_r <= {4{s_dat_i}};
`ifdef WB_BRIDGE_LINEBUF_EN
                        if (lb_hit_s) begin
                            s_ack_r   <= 1'b1;
                            s_dat_o_r <= pick_word(lb_data_r, s_adr[3:2]);
                        end else begin
                            m_cyc_r <= 1'b1;
                        end
`else
                        m_cyc_r <= 1'b1;
`endif
                    end
                end
                ST_REQ: begin
                    to_cnt_r <= to_cnt_r + TO_ONE;
                    if (!s_cyc) begin
                        abort_r <= 1'b1;
                    end
                    // An abandoned cycle still runs to completion, but nothing is reported.
                    if (done_s || timeout_s) begin
                        m_cyc_r  <= 1'b0;
                        to_cnt_r <= '0;
                        s_err_r  <= bus_err_s & deliver_s;
                        s_ack_r  <= ~bus_err_s & deliver_s;
                        if (~bus_err_s & deliver_s & ~m_we_r) begin
                            s_dat_o_r <= pick_word(m_dat_i, lane_r);
                        end
                    end
                end
                ST_RESP: begin
                    s_ack_r <= 1'b0;
                    s_err_r <= 1'b0;
                end
`ifdef WB_BRIDGE_LINEBUF_EN
                ST_HIT: begin
                    s_ack_r <= 1'b0;
                end
`endif
                default: begin
                    m_cyc_r <= 1'b0;
                    s_ack_r <= 1'b0;
                    s_err_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_BRIDGE_LINEBUF_EN
    // Line buffer: reads allocate, writes to the held line merge through, failures invalidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_data_r  <= 128'h0;
            lb_tag_r   <= 28'h0;
            lb_valid_r <= 1'b0;
        end else if ((state_r == ST_REQ) && (done_s || timeout_s)) begin
            if (bus_err_s) begin
                if (line_hit_s) begin
                    lb_valid_r <= 1'b0;
                end
            end else if (!m_we_r) begin
                lb_data_r  <= m_dat_i;
                lb_tag_r   <= m_adr_r[31:4];
                lb_valid_r <= 1'b1;
            end else if (line_hit_s) begin
                lb_data_r <= merge_bytes(lb_data_r, m_dat_o_r, m_sel_r);
            end
        end
    end
`endif

    assign s_dat_o = s_dat_o_r;
    assign s_ack   = s_ack_r;
    assign s_err   = s_err_r;
    assign m_adr   = m_adr_r;
    assign m_dat_o = m_dat_o_r;
    assign m_we    = m_we_r;
    assign m_sel   = m_sel_r;
    assign m_stb   = m_cyc_r;
    assign m_cyc   = m_cyc_r;

endmodule

// File: tb/tb_wb_dram_narrow_bridge.sv
// Scoreboard bench for wb_dram_narrow_bridge: a word-level memory model predicts every
// DRAM request and core response; a negedge monitor compares what the DUT presents.
`timescale 1ns/1ps
module tb_wb_dram_narrow_bridge;
    localparam int TO = 8;
`ifdef WB_BRIDGE_LINEBUF_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s_adr, s_dat_i, s_dat_o;
    logic         s_we, s_stb, s_cyc, s_ack, s_err;
    logic [3:0]   s_sel;
    logic [31:0]  m_adr;
    logic [127:0] m_dat_o, m_dat_i;
    logic         m_we, m_stb, m_cyc, m_ack, m_err;
    logic [15:0]  m_sel;

    wb_dram_narrow_bridge #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_adr(s_adr), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we(s_we), .s_sel(s_sel),
        .s_stb(s_stb), .s_cyc(s_cyc), .s_ack(s_ack), .s_err(s_err),
        .m_adr(m_adr), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we(m_we), .m_sel(m_sel),
        .m_stb(m_stb), .m_cyc(m_cyc), .m_ack(m_ack), .m_err(m_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] adr; logic [15:0] sel; logic [127:0] dat; logic we; int len; } mreq_t;
    typedef struct { logic is_err; logic [31:0] dat; int gap; } resp_t;

    mreq_t        mq[$];
    resp_t        rq[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           st_lat = 0;
    int           st_mode = 0;          // 0 ack, 1 err, 2 ack+err, 3 silent
    bit           late_ack_req = 1'b0;
    logic [127:0] dram_mem [int];
    logic [31:0]  ref_mem [int];
    bit           lb_v = 1'b0;
    int           lb_tag = 0;
    logic [31:0]  last_rd = 32'h0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int w);
        logic [31:0] wv;
        wv = w;
        return (wv * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return init_word(w);
    endfunction

    function automatic logic [127:0] dram_line(input int line);
        logic [127:0] l;
        if (dram_mem.exists(line)) return dram_mem[line];
        for (int i = 0; i < 4; i++) l[32*i +: 32] = init_word(line * 4 + i);
        return l;
    endfunction

    task automatic preload(input int line, input logic [127:0] data);
        dram_mem[line] = data;
        for (int i = 0; i < 4; i++) ref_mem[line * 4 + i] = data[32*i +: 32];
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // DRAM stub: answers each m_stb burst once, after st_lat waiting cycles.
    initial begin
        int  wcnt;
        bit  sdone;
        int  line;
        logic [127:0] l;
        wcnt = 0; sdone = 1'b0;
        m_ack = 1'b0; m_err = 1'b0; m_dat_i = 128'h0;
        forever begin
            @(posedge clk); #1;
            m_ack = 1'b0; m_err = 1'b0;
            m_dat_i = {$urandom, $urandom, $urandom, $urandom};
            if (rst) begin
                wcnt = 0; sdone = 1'b0;
            end else if (m_stb && !sdone) begin
                if (wcnt == st_lat) begin
                    sdone = 1'b1;
                    line = int'(m_adr >> 4);
                    case (st_mode)
                        0: begin
                            m_ack = 1'b1;
                            l = dram_line(line);
                            if (m_we) begin
                                for (int b = 0; b < 16; b++) if (m_sel[b]) l[8*b +: 8] = m_dat_o[8*b +: 8];
                                dram_mem[line] = l;
                            end else begin
                                m_dat_i = l;
                            end
                        end
                        1: m_err = 1'b1;
                        2: begin m_ack = 1'b1; m_err = 1'b1; end
                        default: ;
                    endcase
                end else begin
                    wcnt++;
                end
            end else if (!m_stb) begin
                wcnt = 0; sdone = 1'b0;
                if (late_ack_req) begin m_ack = 1'b1; late_ack_req = 1'b0; end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT starts a DRAM request or responds.
    initial begin
        bit    prev_stb, have_m;
        int    stb_run;
        mreq_t cur_m;
        resp_t r;
        prev_stb = 1'b0; have_m = 1'b0; stb_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stb = 1'b0; have_m = 1'b0; stb_run = 0;
            end else begin
                if (m_stb) begin
                    if (!prev_stb) begin
                        stb_run = 1;
                        if (mq.size() == 0) begin
                            vectors++; miscompares++;
                            $display("FAIL unexpected_m_stb: got request to %h, expected none", m_adr);
                        end else begin
                            cur_m = mq.pop_front(); have_m = 1'b1;
                            chk("m_adr", m_adr, cur_m.adr);
                            chk("m_sel", m_sel, cur_m.sel);
                            chk("m_dat_o", m_dat_o, cur_m.dat);
                            chk("m_we", m_we, cur_m.we);
                            chk("m_cyc", m_cyc, 1'b1);
                        end
                    end else begin
                        stb_run++;
                        if (have_m) chk("m_hold", {m_adr, m_sel, m_we, m_cyc}, {cur_m.adr, cur_m.sel, cur_m.we, 1'b1});
                    end
                end else if (prev_stb && have_m) begin
                    chk("m_stb_len", stb_run, cur_m.len);
                    have_m = 1'b0;
                end
                prev_stb = m_stb;
                if (s_ack || s_err) begin
                    if (rq.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_resp: got ack=%0b err=%0b, expected none", s_ack, s_err);
                    end else begin
                        r = rq.pop_front();
                        chk("s_err", s_err, r.is_err);
                        chk("s_ack", s_ack, !r.is_err);
                        chk("s_dat_o", s_dat_o, r.dat);
                        chk("resp_latency", cyc - start_cyc, r.gap);
                    end
                end
            end
        end
    end

    // One core access; entered and left at #1 after a clock edge with the DUT idle.
    task automatic do_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, input int mode, input int lat_in, input bit abort);
        int          line, w, lat;
        logic [1:0]  lane;
        logic [15:0] ms;
        logic [31:0] wd;
        bit          hit, ok, got;
        line = int'(adr >> 4); w = int'(adr >> 2); lane = adr[3:2];
        lat  = (abort && lat_in < 2) ? 2 : lat_in;
        hit  = LB && !we && lb_v && (lb_tag == line);
        if (hit) begin
            last_rd = ref_word(w);
            rq.push_back('{1'b0, last_rd, 1});
        end else begin
            ms = {12'h000, sel};
            ms = ms << (4 * lane);
            mq.push_back('{{adr[31:4], 4'h0}, ms, {4{dat}}, we, (mode == 3) ? TO : lat + 1});
            ok = (mode == 0);
            if (ok && we) begin
                wd = ref_word(w);
                for (int b = 0; b < 4; b++) if (sel[b]) wd[8*b +: 8] = dat[8*b +: 8];
                ref_mem[w] = wd;
            end
            if (ok && !we) begin lb_v = 1'b1; lb_tag = line; end
            else if (!ok && lb_v && lb_tag == line) lb_v = 1'b0;
            if (!abort) begin
                if (ok) begin
                    if (!we) last_rd = ref_word(w);
                    rq.push_back('{1'b0, last_rd, lat + 2});
                end else begin
                    rq.push_back('{1'b1, last_rd, (mode == 3) ? TO + 1 : lat + 2});
                end
            end
        end
        st_mode = mode; st_lat = (mode == 3) ? 1000 : lat;
        s_adr = adr; s_we = we; s_dat_i = dat; s_sel = sel; s_cyc = 1'b1; s_stb = 1'b1;
        start_cyc = cyc;
        got = 1'b0;
        if (abort) begin
            @(posedge clk); #1; @(posedge clk); #1;
            s_cyc = 1'b0; s_stb = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (!m_stb) begin got = 1'b1; break; end
            end
        end else begin
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (s_ack || s_err) begin got = 1'b1; break; end
            end
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL resp_timeout: got no completion for %h within 40 cycles, expected one", adr);
            rq.delete(); mq.delete();
        end
        s_cyc = 1'b0; s_stb = 1'b0; s_adr = $urandom; s_dat_i = $urandom;
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ack"}, s_ack, 1'b0);
        chk({tag, "_s_err"}, s_err, 1'b0);
        chk({tag, "_s_dat_o"}, s_dat_o, 32'h0);
        chk({tag, "_m_stb"}, m_stb, 1'b0);
        chk({tag, "_m_cyc"}, m_cyc, 1'b0);
        chk({tag, "_m_adr"}, m_adr, 32'h0);
        chk({tag, "_m_dat_o"}, m_dat_o, 128'h0);
        chk({tag, "_m_we"}, m_we, 1'b0);
        chk({tag, "_m_sel"}, m_sel, 16'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        int          r, mode;
        logic        we;
        rst = 1'b1;
        s_adr = 32'h0; s_dat_i = 32'h0; s_we = 1'b0; s_sel = 4'h0; s_stb = 1'b0; s_cyc = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;

        do_access(32'h0000_0028, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 3, 1'b0);
        preload(3, 128'h44444444_33333333_22222222_11111111);
        do_access(32'h0000_0034, 1'b0, 32'h0, 4'hF, 0, 1, 1'b0);
        do_access(32'h0000_0034, 1'b0, 32'h0, 4'hF, 1, 2, 1'b0);
        do_access(32'h0000_003C, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0);
        do_access(32'h0000_0030, 1'b0, 32'h0, 4'hF, 2, 1, 1'b0);
        do_access(32'h0000_0030, 1'b1, 32'h1234_5678, 4'h0, 0, 1, 1'b0);
        do_access(32'h0000_0024, 1'b0, 32'h0, 4'hF, 3, 0, 1'b0);
        late_ack_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        do_access(32'h0000_0028, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0);
        do_access(32'h0000_0050, 1'b1, 32'hCAFE_F00D, 4'h5, 0, 3, 1'b1);
        do_access(32'h0000_0050, 1'b0, 32'h0, 4'hF, 0, 1, 1'b0);

        // Reset asserted while a request is outstanding.
        mq.push_back('{32'h0000_0100, 16'h000F, 128'h0, 1'b0, 0});
        st_mode = 3; st_lat = 1000;
        s_adr = 32'h0000_0100; s_we = 1'b0; s_sel = 4'hF; s_dat_i = 32'h0; s_cyc = 1'b1; s_stb = 1'b1;
        @(posedge clk); #1; @(posedge clk); #1;
        chk("mid_req_m_stb", m_stb, 1'b1);
        #1 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        s_cyc = 1'b0; s_stb = 1'b0; lb_v = 1'b0; last_rd = 32'h0; mq.delete();
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        do_access(32'h0000_0104, 1'b1, 32'h0BAD_F00D, 4'hF, 0, 2, 1'b0);
        do_access(32'h0000_0104, 1'b0, 32'h0, 4'hF, 0, 1, 1'b0);

        do_access(32'h0000_0040, 1'b0, 32'h0, 4'hF, 0, 1, 1'b0);
        do_access(32'h0000_0041, 1'b1, 32'h0000_AB00, 4'b0010, 0, 1, 1'b0);
        do_access(32'h0000_0040, 1'b0, 32'h0, 4'hF, 0, 1, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ra = 32'h0000_1000 + 32'($urandom_range(0, 127));
            r  = $urandom_range(0, 99);
            mode = (r < 75) ? 0 : (r < 85) ? 1 : (r < 92) ? 2 : 3;
            we = 1'($urandom_range(0, 1));
            do_access(ra, we, $urandom, 4'($urandom), mode, $urandom_range(0, 5),
                      we && (mode == 0) && ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", {32'(mq.size()), 32'(rq.size())}, 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
